maxnet_wta_engine: RTL and testbench
====================================

Name: maxnet_wta_engine

Overview:
- Parametrised, self-sequenced MaxNet winner-take-all engine: N channels, data width W, and an epsilon inhibition set as a power-of-two shift.
- Latches N unsigned inputs and iterates mutual inhibition, one update per cycle, until exactly one activation survives.
- Returns the winner's original input value and index.
- Adds what the fixed 4x5-bit datapath lacks: built-in FSM, start/busy and valid/ready handshake, iteration limit with timeout, and deterministic tie resolution.

Parameters:
N, 4, channel count (N >= 2)
W, 5, data width per channel, unsigned
EPS_SHIFT, 2, inhibition factor eps = 2^-EPS_SHIFT
MAX_ITER, 16, maximum committed updates before timeout (>= 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; accepted only in IDLE
x_in  input  N*W  channel i at bits [i*W +: W]
out_ready  input  1  consumer accepts result
busy  output  1  high in ITER and DONE
out_valid  output  1  result fields valid; high only in DONE
result  output  W  latched original input of winning channel
winner_idx  output  clog2(N)  winning channel index
iter_count  output  clog2(MAX_ITER+1)  committed updates performed
tie  output  1  winner chosen by tie rule
timeout  output  1  MAX_ITER reached with more than one nonzero

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; X regs, A regs, result, winner_idx, iter_count, tie, timeout all 0; busy=0; out_valid=0.
- IDLE: on a clock edge with start=1, latch X=x_in, set A=x_in, clear iter_count/tie/timeout, go to ITER. Otherwise hold. Previous result fields stay visible until the next start.
- ITER, evaluated each cycle on the current A:
  - S = sum of A (width W+clog2(N)). For each i: inh_i = (S - A_i) >> EPS_SHIFT; A'_i = (A_i > inh_i) ? A_i - inh_i : 0.
  - Priority 1: nz(A) == 1 -> winner = that index; go to DONE; A not updated.
  - Priority 2: nz(A) == 0 (possible only for all-zero input) -> winner 0, tie=1, go to DONE.
  - Priority 3: all A' == 0 (simultaneous collapse) -> A not committed; winner = lowest index holding max(A); tie=1; go to DONE.
  - Priority 4: iter_count == MAX_ITER -> winner = lowest index holding max(A); timeout=1; go to DONE.
  - Else: A <= A', iter_count++, stay in ITER.
- On any transition to DONE: result <= X[winner]; winner_idx <= winner; out_valid=1 from the following cycle.
- DONE: all outputs held stable while out_ready=0. An edge with out_ready=1 returns to IDLE; out_valid drops the next cycle.
- start is ignored outside IDLE; start in the same cycle as the handshake is ignored.
- Latency: start edge E0; k committed updates at E1..Ek; DONE entered at E(k+1); out_valid high after E(k+1).
- x_in changes after E0 have no effect. The A' arithmetic is purely combinational; no intermediate pipeline.
- Reset asserted mid-ITER or mid-DONE aborts immediately to the reset state.

Test Plan:
1. Basic win (N=4, W=5, EPS_SHIFT=2): x_in={10,6,3,1}, start 1 cycle -> A sequence {8,3,0,0}, {8,1,0,0}, {8,0,0,0}; out_valid after E4; result=10, winner_idx=0, iter_count=3, tie=0, timeout=0.
2. Stuck tie -> timeout (MAX_ITER=16): x_in={0,7,7,0} -> A converges to {0,3,3,0} and stalls; DONE after 16 updates; winner_idx=1, result=7, iter_count=16, timeout=1, tie=0.
3. Collapse tie (second instance, EPS_SHIFT=1): x_in={4,4,4,4} -> first A' is all zero and not committed; winner_idx=0, result=4, tie=1, iter_count=0, out_valid after E1.
4. Zero input: x_in={0,0,0,0} -> winner_idx=0, result=0, tie=1, iter_count=0. Single nonzero {0,0,9,0} -> winner_idx=2, result=9, iter_count=0.
5. Handshake: in case 1, hold out_ready=0 for 5 cycles while pulsing start and changing x_in -> outputs stable, start ignored. Raise out_ready -> IDLE; a new start then processes the new x_in.
6. Reset mid-run: assert rst=0 asynchronously between clock edges during ITER of case 2 -> all outputs 0 immediately. Release, then rerun case 1 -> identical results.

Source files
------------

// File: rtl/maxnet_wta_engine.sv
// MaxNet winner-take-all engine: latches N unsigned inputs, iterates mutual
// inhibition one update per cycle, and reports the surviving channel.
module maxnet_wta_engine #(
  parameter int N         = 4,
  parameter int W         = 5,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 16,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(MAX_ITER + 1),
  localparam int SW = W + $clog2(N),
  localparam int NW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*W-1:0]  x_in,
  input  logic            out_ready,
  output logic            busy,
  output logic            out_valid,
  output logic [W-1:0]    result,
  output logic [IW-1:0]   winner_idx,
  output logic [CW-1:0]   iter_count,
  output logic            tie,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t state, state_next;

  logic [W-1:0]  x_reg  [N];
  logic [W-1:0]  a_reg  [N];
  logic [W-1:0]  a_next [N];
  logic [SW-1:0] inh    [N];
  logic [SW-1:0] sum;
  logic [NW-1:0] nz_count;
  logic [IW-1:0] nz_idx;
  logic [IW-1:0] max_idx;
  logic [W-1:0]  max_val;
  logic          all_collapse;
  logic          go_done;
  logic          set_tie;
  logic          set_timeout;
  logic [IW-1:0] win;

  // One full inhibition step plus the winner-selection summaries of the current A.
  always_comb begin
    sum          = '0;
    nz_count     = '0;
    nz_idx       = '0;
    max_idx      = '0;
    max_val      = a_reg[0];
    all_collapse = 1'b1;
    for (int i = 0; i < N; i++) begin
      sum = sum + SW'(a_reg[i]);
    end
    for (int i = 0; i < N; i++) begin
      inh[i]    = (sum - SW'(a_reg[i])) >> EPS_SHIFT;
      a_next[i] = (SW'(a_reg[i]) > inh[i]) ? a_reg[i] - inh[i][W-1:0] : '0;
      if (a_next[i] != '0) all_collapse = 1'b0;
      if (a_reg[i] != '0) begin
        nz_count = nz_count + NW'(1);
        nz_idx   = IW'(i);
      end
      if (a_reg[i] > max_val) begin
        max_val = a_reg[i];
        max_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_next  = state;
    go_done     = 1'b0;
    win         = '0;
    set_tie     = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE: if (start) state_next = ITER;
      ITER: begin
        go_done    = 1'b1;
        state_next = DONE;
        if (nz_count == NW'(1)) begin
          win = nz_idx;
        end else if (nz_count == '0) begin
          set_tie = 1'b1;
        end else if (all_collapse) begin
          win     = max_idx;
          set_tie = 1'b1;
        end else if (iter_count == CW'(MAX_ITER)) begin
          win         = max_idx;
          set_timeout = 1'b1;
        end else begin
          go_done    = 1'b0;
          state_next = ITER;
        end
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Result fields are only rewritten on a new start or when a winner is decided.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        x_reg[i] <= '0;
        a_reg[i] <= '0;
      end
      result     <= '0;
      winner_idx <= '0;
      iter_count <= '0;
      tie        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              x_reg[i] <= x_in[i*W +: W];
              a_reg[i] <= x_in[i*W +: W];
            end
            iter_count <= '0;
            tie        <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        ITER: begin
          if (go_done) begin
            result     <= x_reg[win];
            winner_idx <= win;
            tie        <= set_tie;
            timeout    <= set_timeout;
          end else begin
            for (int i = 0; i < N; i++) a_reg[i] <= a_next[i];
            iter_count <= iter_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_maxnet_wta_engine.sv
// Randomized and directed bench for maxnet_wta_engine; two instances
// (eps = 1/4 and eps = 1/2) checked against an integer MaxNet model.
module tb_maxnet_wta_engine;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int IW = 2;
  localparam int CW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start, start2, out_ready, out_ready2;
  logic [N*W-1:0] x_in, x_in2;
  logic           busy, busy2, out_valid, out_valid2;
  logic [W-1:0]   result, result2;
  logic [IW-1:0]  winner_idx, winner_idx2;
  logic [CW-1:0]  iter_count, iter_count2;
  logic           tie, tie2, timeout, timeout2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  maxnet_wta_engine #(.N(N), .W(W), .EPS_SHIFT(2), .MAX_ITER(16)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .out_ready(out_ready),
    .busy(busy), .out_valid(out_valid), .result(result), .winner_idx(winner_idx),
    .iter_count(iter_count), .tie(tie), .timeout(timeout)
  );

  maxnet_wta_engine #(.N(N), .W(W), .EPS_SHIFT(1), .MAX_ITER(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .x_in(x_in2), .out_ready(out_ready2),
    .busy(busy2), .out_valid(out_valid2), .result(result2), .winner_idx(winner_idx2),
    .iter_count(iter_count2), .tie(tie2), .timeout(timeout2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Integer MaxNet: iterate the inhibition rule on plain ints until one survivor.
  function automatic void refModel(input int xv[4], input int sh, output int res, output int idx,
                                   output int its, output int t, output int tmo);
    int a[4];
    int an[4];
    int s, nz, best, last;
    bit fin, allz;
    a = xv; its = 0; t = 0; tmo = 0; idx = 0; fin = 0;
    for (int g = 0; g < 100 && !fin; g++) begin
      nz = 0; s = 0; best = 0; last = 0;
      for (int i = 0; i < 4; i++) begin
        s += a[i];
        if (a[i] != 0) begin nz++; last = i; end
        if (a[i] > a[best]) best = i;
      end
      allz = 1;
      for (int i = 0; i < 4; i++) begin
        an[i] = (a[i] > ((s - a[i]) >> sh)) ? a[i] - ((s - a[i]) >> sh) : 0;
        if (an[i] != 0) allz = 0;
      end
      if (nz == 1) begin idx = last; fin = 1; end
      else if (nz == 0) begin idx = 0; t = 1; fin = 1; end
      else if (allz) begin idx = best; t = 1; fin = 1; end
      else if (its == 16) begin idx = best; tmo = 1; fin = 1; end
      else begin a = an; its++; end
    end
    res = xv[idx];
  endfunction

  function automatic logic [31:0] getField(input int sel, input int f);
    case (f)
      0: return sel != 0 ? 32'(out_valid2)   : 32'(out_valid);
      1: return sel != 0 ? 32'(busy2)        : 32'(busy);
      2: return sel != 0 ? 32'(result2)      : 32'(result);
      3: return sel != 0 ? 32'(winner_idx2)  : 32'(winner_idx);
      4: return sel != 0 ? 32'(iter_count2)  : 32'(iter_count);
      5: return sel != 0 ? 32'(tie2)         : 32'(tie);
      default: return sel != 0 ? 32'(timeout2) : 32'(timeout);
    endcase
  endfunction

  task automatic drive(input int sel, input logic st, input logic [N*W-1:0] vec, input logic rdy);
    if (sel != 0) begin start2 = st; x_in2 = vec; out_ready2 = rdy; end
    else begin start = st; x_in = vec; out_ready = rdy; end
  endtask

  // One transaction: start, wait for out_valid, check fields, optionally hand off.
  task automatic applyStimulus(input int sel, input logic [N*W-1:0] vec, input string tag,
                               input bit release_done);
    int xv[4];
    int er, ei, eit, et, eto, cyc;
    for (int i = 0; i < 4; i++) xv[i] = int'(vec[i*W +: W]);
    refModel(xv, (sel != 0) ? 1 : 2, er, ei, eit, et, eto);
    @(negedge clk);
    drive(sel, 1'b1, vec, 1'b0);
    @(negedge clk);
    drive(sel, 1'b0, ~vec, 1'b0);
    checkOutput({tag, " busy"}, getField(sel, 1), 1);
    cyc = 0;
    while (getField(sel, 0) != 1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, eit + 1);
    checkOutput({tag, " result"},  getField(sel, 2), er);
    checkOutput({tag, " winner"},  getField(sel, 3), ei);
    checkOutput({tag, " iters"},   getField(sel, 4), eit);
    checkOutput({tag, " tie"},     getField(sel, 5), et);
    checkOutput({tag, " timeout"}, getField(sel, 6), eto);
    if (release_done) begin
      drive(sel, 1'b0, ~vec, 1'b1);
      @(negedge clk);
      drive(sel, 1'b0, ~vec, 1'b0);
      checkOutput({tag, " valid drop"}, getField(sel, 0), 0);
      checkOutput({tag, " idle"},       getField(sel, 1), 0);
      checkOutput({tag, " held"},       getField(sel, 2), er);
    end
  endtask

  task automatic checkReset(input string tag);
    for (int s = 0; s < 2; s++)
      for (int f = 0; f < 7; f++)
        checkOutput($sformatf("%s s%0d f%0d", tag, s, f), getField(s, f), 0);
  endtask

  initial begin
    logic [N*W-1:0] vec;
    rst = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    #2 rst = 1'b0;
    #1 checkReset("reset");
    @(negedge clk) rst = 1'b1;

    applyStimulus(0, {5'd1, 5'd3, 5'd6, 5'd10}, "basic", 1);
    applyStimulus(0, {5'd0, 5'd7, 5'd7, 5'd0}, "stuck", 1);
    applyStimulus(1, {5'd4, 5'd4, 5'd4, 5'd4}, "collapse", 1);
    applyStimulus(0, {5'd0, 5'd0, 5'd0, 5'd0}, "zero", 1);
    applyStimulus(0, {5'd0, 5'd9, 5'd0, 5'd0}, "single", 1);

    // Handshake: hold DONE while poking start and x_in.
    applyStimulus(0, {5'd1, 5'd3, 5'd6, 5'd10}, "hs", 0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 1'b1, N*W'($urandom), 1'b0);
      @(negedge clk);
      checkOutput($sformatf("hs hold valid %0d", c), 32'(out_valid), 1);
      checkOutput($sformatf("hs hold result %0d", c), 32'(result), 10);
      checkOutput($sformatf("hs hold iters %0d", c), 32'(iter_count), 3);
    end
    drive(0, 1'b1, {5'd0, 5'd0, 5'd9, 5'd0}, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    checkOutput("hs start ignored", 32'(busy), 0);
    applyStimulus(0, {5'd0, 5'd9, 5'd0, 5'd0}, "hs new", 1);

    // Reset asserted between edges while ITER is running.
    @(negedge clk);
    drive(0, 1'b1, {5'd0, 5'd7, 5'd7, 5'd0}, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, '0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("midrun busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1 checkReset("midrun reset");
    @(negedge clk) rst = 1'b1;
    applyStimulus(0, {5'd1, 5'd3, 5'd6, 5'd10}, "rerun", 1);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++)
        vec[i*W +: W] = W'((r % 2 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3));
      applyStimulus(r % 2, vec, $sformatf("rand%0d", r), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
